pwm_fade: RTL and testbench
===========================

PWM_FADE -- requirements
Module: pwm_fade

Interface
REQ-001 SHALL have parameter SCALE, default 256: PWM resolution; one PWM period = SCALE clocks; W = $clog2(SCALE)+1.
REQ-002 SHALL have parameter STEP, default 1: level increment/decrement per step event, range 1..SCALE.
REQ-003 SHALL have parameter STEP_PERIODS, default 4: PWM periods per step event, >= 1.
REQ-004 SHALL have parameter HOLD_PERIODS, default 64: PWM periods spent at peak, >= 1.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port n_rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port enable  input  1  level-sensitive fade request.
REQ-008 SHALL have port max_level  input  W  peak duty level; values > SCALE treated as SCALE.
REQ-009 SHALL have port value  output  W  duty level, registered, drives the pwm duty input directly.
REQ-010 SHALL have port phase  output  2  current state: 0 IDLE, 1 UP, 2 HOLD, 3 DOWN.
REQ-011 SHALL have port cycle_done  output  1  one-clock pulse on completion of a fade cycle.

Function
REQ-012 SHALL keep a period counter pcnt counting 0..SCALE-1 and wrapping to 0, advancing every clock while n_rst=1, so it tracks the downstream PWM counter after a common reset.
REQ-013 SHALL define tick = (pcnt == SCALE-1); value and phase SHALL change only on a tick edge, so the PWM never sees a mid-period duty change.
REQ-014 SHALL keep a step counter counting ticks 0..STEP_PERIODS-1; step event = tick with step counter at STEP_PERIODS-1; step counter cleared to 0 on every state entry.
REQ-015 IDLE: value=0; on tick with enable=1 -> UP (value unchanged); otherwise stay.
REQ-016 UP: on each step event value <= min(value+STEP, Lmax), Lmax = min(max_level, SCALE); when the new value equals Lmax -> HOLD on the same edge.
REQ-017 UP with Lmax=0: first step event -> HOLD with value 0.
REQ-018 HOLD: value held (not re-clamped to later max_level changes); after HOLD_PERIODS ticks -> DOWN.
REQ-019 DOWN: on each step event value <= value-STEP, saturating at 0; when new value is 0 -> cycle_done=1 for exactly that clock's output and next state = UP if enable=1 at that edge, else IDLE.
REQ-020 enable=0 sampled on a tick in UP or HOLD SHALL force transition to DOWN on that edge (value unchanged); enable changes in DOWN SHALL not abort the ramp.
REQ-021 Arithmetic SHALL use W+1 bits internally; value SHALL never exceed SCALE nor wrap below 0.
REQ-022 cycle_done SHALL be 0 at all other times; it SHALL be registered alongside value.

Reset
REQ-023 n_rst=0 at a rising edge SHALL set pcnt=0, step counter=0, value=0, phase=IDLE, cycle_done=0, overriding any other event that edge.
REQ-024 Reset asserted mid-ramp SHALL abort the cycle with no cycle_done pulse; operation restarts from IDLE at the first tick after release.

Verification (SCALE=16, STEP=4, STEP_PERIODS=1, HOLD_PERIODS=2, max_level=16, ticks numbered from release)
REQ-025 Reset held, enable=1 -> value=0, phase=0, cycle_done=0 every cycle.
REQ-026 enable=1 from release -> tick1 UP; ticks 2..5 value 4,8,12,16, HOLD at tick5; DOWN at tick7; ticks 8..11 value 12,8,4,0; cycle_done one clock at tick11; phase=UP after tick11.
REQ-027 Same, enable dropped before tick11 -> phase IDLE after tick11, value stays 0, no further ticks change state.
REQ-028 max_level=10 -> UP values 4,8,10 then HOLD at 10; DOWN values 6,2,0.
REQ-029 enable dropped during UP at value 8 -> DOWN on next tick, then 4,0 with cycle_done; value never exceeded 8; value stable between ticks throughout.
REQ-030 n_rst pulsed low at value 12 in DOWN -> value 0, phase IDLE next edge, no cycle_done; pcnt restarts at 0.

Source files
------------

// File: rtl/pwm_fade.sv
// PWM fade sequencer: ramps a duty level up, holds it, then ramps it down,
// updating only on PWM period boundaries so the duty never glitches mid-period.
module pwm_fade #(
  parameter int SCALE        = 256,
  parameter int STEP         = 1,
  parameter int STEP_PERIODS = 4,
  parameter int HOLD_PERIODS = 64,
  localparam int W           = $clog2(SCALE) + 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         enable,
  input  logic [W-1:0] max_level,
  output logic [W-1:0] value,
  output logic [1:0]   phase,
  output logic         cycle_done
);

  localparam int PW   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CMAX = (STEP_PERIODS > HOLD_PERIODS) ?
                        STEP_PERIODS : HOLD_PERIODS;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [PW-1:0] PLAST   = PW'(SCALE - 1);
  localparam logic [CW-1:0] SLAST   = CW'(STEP_PERIODS - 1);
  localparam logic [CW-1:0] HLAST   = CW'(HOLD_PERIODS - 1);
  localparam logic [W-1:0]  SCALE_W = W'(SCALE);
  localparam logic [W-1:0]  STEP_W  = W'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } state_t;

  state_t        state_q;
  logic [PW-1:0] pcnt_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  value_q;
  logic          done_q;

  logic          tick;
  logic          step;
  logic [W-1:0]  lmax;
  logic [W:0]    sum_x;
  logic [W-1:0]  up_d;
  logic [W-1:0]  dn_d;

  always_comb begin
    tick  = (pcnt_q == PLAST);
    step  = tick && (cnt_q == SLAST);
    lmax  = (max_level > SCALE_W) ? SCALE_W : max_level;
    // one extra bit so value+STEP cannot wrap before the clamp
    sum_x = {1'b0, value_q} + {1'b0, STEP_W};
    up_d  = (sum_x >= {1'b0, lmax}) ? lmax : sum_x[W-1:0];
    dn_d  = (value_q > STEP_W) ? (value_q - STEP_W) : '0;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      done_q  <= 1'b0;
    end else begin
      pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
      done_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          IDLE: begin
            value_q <= '0;
            if (enable) begin
              state_q <= UP;
              cnt_q   <= '0;
            end
          end
          UP: begin
            if (!enable) begin
              state_q <= DOWN;
              cnt_q   <= '0;
            end else if (step) begin
              value_q <= up_d;
              cnt_q   <= '0;
              if (up_d == lmax) state_q <= HOLD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          HOLD: begin
            if (!enable || cnt_q == HLAST) begin
              state_q <= DOWN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DOWN: begin
            if (step) begin
              value_q <= dn_d;
              cnt_q   <= '0;
              if (dn_d == '0) begin
                done_q  <= 1'b1;
                state_q <= enable ? UP : IDLE;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign value      = value_q;
  assign phase      = state_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_pwm_fade.sv
// Scoreboard bench for pwm_fade: driver pushes per-tick expectations from a
// tick-level model, monitor pops and compares at each period boundary.
module tb_pwm_fade;

  localparam int SCALE = 16;
  localparam int STEP  = 4;
  localparam int SP    = 1;
  localparam int HP    = 2;
  localparam int W     = $clog2(SCALE) + 1;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         enable = 1'b1;
  logic [W-1:0] max_level = W'(16);
  logic [W-1:0] value;
  logic [1:0]   phase;
  logic         cycle_done;

  pwm_fade #(
    .SCALE(SCALE),
    .STEP(STEP),
    .STEP_PERIODS(SP),
    .HOLD_PERIODS(HP)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .enable(enable),
    .max_level(max_level),
    .value(value),
    .phase(phase),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int p;
    int cd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  int   exp_v = 0;
  int   exp_p = 0;

  // model: phase 0..3, level, ticks spent in current phase
  int m_ph;
  int m_v;
  int m_t;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0;
    m_v  = 0;
    m_t  = 0;
  endtask

  task automatic enter(input int ph);
    m_ph = ph;
    m_t  = 0;
  endtask

  task automatic model_tick(input int en, input int ml, output exp_t e);
    int lmax;
    int cd;
    lmax = (ml > SCALE) ? SCALE : ml;
    cd = 0;
    m_t++;
    case (m_ph)
      0: begin
        m_v = 0;
        if (en != 0) enter(1);
      end
      1: begin
        if (en == 0) enter(3);
        else if (m_t % SP == 0) begin
          m_v = (m_v + STEP > lmax) ? lmax : m_v + STEP;
          if (m_v == lmax) enter(2);
        end
      end
      2: begin
        if (en == 0 || m_t == HP) enter(3);
      end
      default: begin
        if (m_t % SP == 0) begin
          m_v = (m_v - STEP < 0) ? 0 : m_v - STEP;
          if (m_v == 0) begin
            cd = 1;
            enter((en != 0) ? 1 : 0);
          end
        end
      end
    endcase
    e.v  = m_v;
    e.p  = m_ph;
    e.cd = cd;
  endtask

  task automatic period(input int en, input int ml);
    exp_t e;
    enable    = (en != 0);
    max_level = W'(ml);
    model_tick(en, ml, e);
    q.push_back(e);
    repeat (SCALE) @(negedge clk);
  endtask

  task automatic pulse_reset(input int off);
    repeat (off) @(negedge clk);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    model_reset();
  endtask

  always @(posedge clk) ncyc <= n_rst ? ncyc + 1 : 0;

  always @(negedge clk) begin
    exp_t e;
    if (ncyc == 0) begin
      exp_v = 0;
      exp_p = 0;
      check("rst_value", int'(value), 0);
      check("rst_phase", int'(phase), 0);
      check("rst_done", int'(cycle_done), 0);
    end else if (ncyc % SCALE == 0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tick_queue: got empty expected entry at %0t", $time);
      end else begin
        e = q.pop_front();
        exp_v = e.v;
        exp_p = e.p;
        check("tick_value", int'(value), e.v);
        check("tick_phase", int'(phase), e.p);
        check("tick_done", int'(cycle_done), e.cd);
      end
    end else begin
      check("stable_value", int'(value), exp_v);
      check("stable_phase", int'(phase), exp_p);
      check("idle_done", int'(cycle_done), 0);
    end
  end

  initial begin
    int guard;
    model_reset();
    repeat (5) @(negedge clk);
    n_rst = 1'b1;

    // full cycle, enable dropped before the final down step
    for (int i = 0; i < 10; i++) period(1, 16);
    period(0, 16);
    for (int i = 0; i < 3; i++) period(0, 16);

    // peak limited to 10, back-to-back cycles
    for (int i = 0; i < 14; i++) period(1, 10);
    for (int i = 0; i < 6; i++) period(0, 10);

    // abort the up ramp at level 8
    guard = 0;
    while (!(m_ph == 1 && m_v == 8) && guard < 40) begin
      period(1, 16);
      guard++;
    end
    check("reach_up8", (m_ph == 1 && m_v == 8) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++) period(0, 16);

    // reset in the middle of the down ramp at level 12
    guard = 0;
    while (!(m_ph == 3 && m_v == 12) && guard < 40) begin
      period(1, 16);
      guard++;
    end
    check("reach_down12", (m_ph == 3 && m_v == 12) ? 1 : 0, 1);
    pulse_reset(3);
    for (int i = 0; i < 4; i++) period(1, 16);

    // randomized enable / peak, with occasional resets
    for (int i = 0; i < 200; i++) begin
      period(($urandom_range(0, 9) != 0) ? 1 : 0, $urandom_range(0, 31));
      if ($urandom_range(0, 39) == 0) pulse_reset($urandom_range(1, SCALE - 1));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
